// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx serializer between NUM_REQ byte producers. Arbitration
//   is round-robin per byte, or per message when LOCK=1 (the grant is held
//   until the owner's byte flagged req_last is accepted). Exactly one tx_we
//   pulse is issued per transmitted frame; the next byte waits for the
//   transmitter's empty flag to fall and rise again.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   req_valid   per-requester byte valid
//   req_data    requester i byte at [8i+7:8i]
//   req_last    byte is last of a message (LOCK=1 only)
//   req_ready   combinational accept strobe, at most one bit high
//   tx_we       registered one-cycle write strobe to uart_tx
//   tx_din      registered byte to uart_tx
//   tx_empty    uart_tx empty flag (1 = idle)
//   grant_id    index of the current/last owner
//   locked      message lock held
//   busy        arbiter not in IDLE
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int LOCK         = 1,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_we,
    output logic [7:0]           tx_din,
    input  logic                 tx_empty,
    output logic [ID_W-1:0]      grant_id,
    output logic                 locked,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] scan_idx;
    logic            cand_valid;
    logic            accept;
    logic            to_fire;
    logic [31:0]     to_cnt;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
        return (32'(i) == 32'(NUM_REQ - 1)) ? '0 : i + ID_W'(1);
    endfunction

    // Candidate selection: the lock owner only, or the first valid requester
    // at or above the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        winner     = grant_id;
        cand_valid = 1'b0;
        scan_idx   = '0;
        if (locked) begin
            cand_valid = req_valid[grant_id];
        end else begin
            for (int unsigned i = 0; i < 32'(NUM_REQ); i++) begin
                scan_idx = ID_W'((32'(rr_ptr) + i) % 32'(NUM_REQ));
                if (!cand_valid && req_valid[scan_idx]) begin
                    cand_valid = 1'b1;
                    winner     = scan_idx;
                end
            end
        end
    end

    assign accept    = (state == IDLE) && tx_empty && !rst && cand_valid;
    assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

    // Force-release of a lock whose owner has gone quiet while we sit in IDLE.
    assign to_fire = (LOCK_TIMEOUT != 0) && (state == IDLE) && locked &&
                     !req_valid[grant_id] && (to_cnt == 32'(LOCK_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (accept)    state_nxt = ISSUE;
            ISSUE:                     state_nxt = WAIT_START;
            WAIT_START: if (!tx_empty) state_nxt = WAIT_DONE;
            WAIT_DONE:  if (tx_empty)  state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_we    <= 1'b0;
            tx_din   <= '0;
            grant_id <= '0;
            locked   <= 1'b0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            to_cnt   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            tx_we <= accept;
            if (accept) begin
                tx_din   <= req_data[{winner, 3'b000} +: 8];
                grant_id <= winner;
                to_cnt   <= '0;
                if ((LOCK != 0) && !req_last[winner]) begin
                    locked <= 1'b1;
                end else begin
                    locked <= 1'b0;
                    rr_ptr <= next_idx(winner);
                end
            end else if (to_fire) begin
                locked <= 1'b0;
                rr_ptr <= next_idx(grant_id);
                to_cnt <= '0;
            end else if (!locked) begin
                to_cnt <= '0;
            end else if ((LOCK_TIMEOUT != 0) && (state == IDLE) && !req_valid[grant_id]) begin
                to_cnt <= to_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Instance 0 runs with LOCK=1 and a
// 16-cycle lock timeout; instance 1 runs with LOCK=0. Each instance has a
// small uart_tx stand-in (empty falls the cycle after tx_we, stays low for
// FRAME cycles) and per-requester byte queues that hold valid/data until
// accepted.
module tb_uart_tx_arbiter;

    localparam int FRAME = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic mdl_clr = 1'b0;

    always #5 clk = ~clk;

    logic [3:0]  rv [2];
    logic [3:0]  rl [2];
    logic [31:0] rd [2];
    logic [3:0]  rdy [2];
    logic        tx_we [2];
    logic [7:0]  tx_din [2];
    logic        tx_empty [2];
    logic [1:0]  gid [2];
    logic        lck [2];
    logic        bsy [2];

    logic [3:0]  acc [2] = '{4'h0, 4'h0};
    int          cnt [2] = '{0, 0};
    int          viol [2] = '{0, 0};
    bit          armed [2] = '{1'b0, 1'b0};
    bit          seen_low [2] = '{1'b0, 1'b0};

    logic [8:0]  rq [8][$];
    logic [10:0] log_q [2][$];

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .LOCK(1), .LOCK_TIMEOUT(16)) u_lock (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_data(rd[0]), .req_last(rl[0]), .req_ready(rdy[0]),
        .tx_we(tx_we[0]), .tx_din(tx_din[0]), .tx_empty(tx_empty[0]),
        .grant_id(gid[0]), .locked(lck[0]), .busy(bsy[0])
    );

    uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .LOCK(0), .LOCK_TIMEOUT(0)) u_rr (
        .clk(clk), .rst(rst),
        .req_valid(rv[1]), .req_data(rd[1]), .req_last(rl[1]), .req_ready(rdy[1]),
        .tx_we(tx_we[1]), .tx_din(tx_din[1]), .tx_empty(tx_empty[1]),
        .grant_id(gid[1]), .locked(lck[1]), .busy(bsy[1])
    );

    assign tx_empty[0] = (cnt[0] == 0) && !hold;
    assign tx_empty[1] = (cnt[1] == 0) && !hold;

    // Transmitter stand-in, output log and accept capture.
    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            acc[j] = rdy[j];
            if (!tx_empty[j]) seen_low[j] = 1'b1;
            else if (seen_low[j]) begin
                armed[j]    = 1'b0;
                seen_low[j] = 1'b0;
            end
            if (mdl_clr) cnt[j] <= 0;
            else if (tx_we[j]) begin
                cnt[j] <= FRAME;
                log_q[j].push_back({lck[j], gid[j], tx_din[j]});
                if (armed[j]) viol[j] = viol[j] + 1;
                armed[j] = 1'b1;
            end else if (cnt[j] != 0) cnt[j] <= cnt[j] - 1;
        end
    end

    // Requester driver: present queue fronts, pop what was accepted.
    initial begin
        logic [8:0] e;
        for (int j = 0; j < 2; j++) begin
            rv[j] = '0;
            rl[j] = '0;
            rd[j] = '0;
        end
        forever begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                for (int i = 0; i < 4; i++) begin
                    if (acc[j][i] && rq[j*4+i].size() > 0) void'(rq[j*4+i].pop_front());
                    if (rq[j*4+i].size() > 0) begin
                        e = rq[j*4+i][0];
                        rv[j][i]        = 1'b1;
                        rl[j][i]        = e[8];
                        rd[j][8*i +: 8] = e[7:0];
                    end else begin
                        rv[j][i]        = 1'b0;
                        rl[j][i]        = 1'b0;
                        rd[j][8*i +: 8] = 8'h00;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_log(input int j, input int n, input bit idle, input int max);
        int k;
        k = 0;
        while (k < max && !(log_q[j].size() >= n && (!idle || (!bsy[j] && tx_empty[j])))) begin
            tick();
            k++;
        end
        check("wait_log", 32'(k < max), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [10:0] exp3 [6];
        exp3 = '{{1'b0, 2'd0, 8'h40}, {1'b1, 2'd1, 8'h61}, {1'b1, 2'd1, 8'h62},
                 {1'b0, 2'd1, 8'h63}, {1'b0, 2'd3, 8'h33}, {1'b0, 2'd0, 8'h30}};

        // Reset state; requester 2 already valid while rst is high.
        rq[2].push_back({1'b1, 8'h55});
        tick();
        check("rst_ready", 32'(rdy[0]), 32'h0);
        check("rst_we", 32'(tx_we[0]), 32'h0);
        check("rst_din", 32'(tx_din[0]), 32'h0);
        check("rst_gid", 32'(gid[0]), 32'h0);
        check("rst_locked", 32'(lck[0]), 32'h0);
        check("rst_busy", 32'(bsy[0]), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Single requester, last byte.
        tick();
        check("t1_ready", 32'(rdy[0]), 32'h4);
        tick();
        check("t1_we", 32'(tx_we[0]), 32'h1);
        check("t1_din", 32'(tx_din[0]), 32'h55);
        check("t1_gid", 32'(gid[0]), 32'h2);
        check("t1_locked", 32'(lck[0]), 32'h0);
        check("t1_busy", 32'(bsy[0]), 32'h1);
        check("t1_ready_off", 32'(rdy[0]), 32'h0);
        tick();
        check("t1_we_pulse", 32'(tx_we[0]), 32'h0);
        wait_log(0, 1, 1'b1, 100);
        check("t1_log", 32'(log_q[0][0]), 32'h255);

        // LOCK=0 rotation with all four requesters valid (req_last ignored).
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                rq[4+i].push_back({1'b0, 8'(8'hA0 + i)});
        wait_log(1, 8, 1'b1, 400);
        for (int k = 0; k < 8; k++)
            check("t2_rot", 32'(log_q[1][k]), 32'((k % 4) * 256 + 160 + (k % 4)));

        // Wrap from pointer 3 to requester 0, then a locked 3-byte message.
        log_q[0].delete();
        rq[0].push_back({1'b1, 8'h40});
        rq[0].push_back({1'b1, 8'h30});
        rq[1].push_back({1'b0, 8'h61});
        rq[1].push_back({1'b0, 8'h62});
        rq[1].push_back({1'b1, 8'h63});
        wait_log(0, 1, 1'b1, 100);
        rq[3].push_back({1'b1, 8'h33});
        wait_log(0, 6, 1'b1, 400);
        for (int k = 0; k < 6; k++)
            check("t3_msg", 32'(log_q[0][k]), 32'(exp3[k]));

        // Lock timeout: owner 0 goes quiet after a non-last byte.
        log_q[0].delete();
        rq[0].push_back({1'b0, 8'h70});
        wait_log(0, 1, 1'b1, 100);
        check("t4_locked", 32'(lck[0]), 32'h1);
        check("t4_gid0", 32'(gid[0]), 32'h0);
        rq[2].push_back({1'b1, 8'h72});
        n = 0;
        while (lck[0] && n < 40) begin
            n++;
            tick();
        end
        check("t4_to_cycles", 32'(n), 32'd16);
        check("t4_ready", 32'(rdy[0]), 32'h4);
        tick();
        check("t4_we", 32'(tx_we[0]), 32'h1);
        check("t4_din", 32'(tx_din[0]), 32'h72);
        check("t4_gid", 32'(gid[0]), 32'h2);
        wait_log(0, 2, 1'b1, 100);

        // Reset while in WAIT_DONE.
        log_q[0].delete();
        rq[1].push_back({1'b1, 8'h15});
        wait_log(0, 1, 1'b0, 100);
        tick();
        tick();
        check("t5_busy_pre", 32'(bsy[0]), 32'h1);
        rst = 1'b1;
        mdl_clr = 1'b1;
        rq[3].push_back({1'b1, 8'h38});
        @(posedge clk);
        #2;
        rst = 1'b0;
        mdl_clr = 1'b0;
        tick();
        check("t5_busy", 32'(bsy[0]), 32'h0);
        check("t5_we", 32'(tx_we[0]), 32'h0);
        check("t5_locked", 32'(lck[0]), 32'h0);
        check("t5_gid", 32'(gid[0]), 32'h0);
        check("t5_ready", 32'(rdy[0]), 32'h8);
        tick();
        check("t5_we2", 32'(tx_we[0]), 32'h1);
        check("t5_din", 32'(tx_din[0]), 32'h38);
        wait_log(0, 2, 1'b1, 100);

        // Transmitter busy from outside while in IDLE.
        hold = 1'b1;
        rq[0].push_back({1'b1, 8'h0F});
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (rdy[0] != 4'h0 || tx_we[0]) bad++;
        end
        check("t6_blocked", 32'(bad), 32'd0);
        hold = 1'b0;
        #1;
        check("t6_ready", 32'(rdy[0]), 32'h1);
        tick();
        check("t6_we", 32'(tx_we[0]), 32'h1);
        check("t6_din", 32'(tx_din[0]), 32'h0F);
        wait_log(0, 3, 1'b1, 100);

        check("one_we_per_frame_lock", 32'(viol[0]), 32'd0);
        check("one_we_per_frame_rr", 32'(viol[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between NUM_REQ byte producers (e.g. CPU console, debug monitor, boot loader).
- Round-robin arbitration per byte, or per message when LOCK=1 and the requester marks its last byte.
- Drives the transmitter's we/din and tracks its empty flag, so it issues exactly one write per transmitted frame.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; NUM_REQ <= 2**ID_W
LOCK, 1, 1 = hold grant until a byte with req_last is accepted; 0 = re-arbitrate every byte
LOCK_TIMEOUT, 65535, idle cycles in IDLE with owner's req_valid low before a lock is force-released; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i]
req_last  in  NUM_REQ  byte is last of message (used when LOCK=1)
req_ready  out  NUM_REQ  byte accepted this cycle when valid&ready; combinational, at most one bit high
tx_we  out  1  write strobe to uart_tx, one-cycle pulse, registered
tx_din  out  8  byte to uart_tx, registered, stable while tx_we high
tx_empty  in  1  uart_tx empty flag (1 = idle, can accept)
grant_id  out  ID_W  index of the current/last owner, registered
locked  out  1  message lock held, registered
busy  out  1  state != IDLE, registered

Behaviour:
- Reset (rst=1 at posedge) values: state=IDLE, tx_we=0, tx_din=0, grant_id=0, locked=0, busy=0, rr pointer=0, timeout counter=0. Applies mid-frame: any byte in flight on the arbiter side is dropped; no req_ready during reset cycle.
- States:
  - IDLE: not locked → winner = first i with req_valid[i] searching from pointer upward, wrapping modulo NUM_REQ. Locked → candidate is grant_id only.
    - req_ready[winner]=1 iff state==IDLE, tx_empty=1, rst=0, req_valid[winner]=1; all other bits 0.
    - On accept: tx_din<=data, tx_we<=1, grant_id<=winner, state<=ISSUE.
  - ISSUE (1 cycle): tx_we high this cycle; next tx_we<=0, state<=WAIT_START.
  - WAIT_START: stay until tx_empty=0, then WAIT_DONE.
  - WAIT_DONE: stay until tx_empty=1, then IDLE.
- Latency: accept at cycle t; tx_we=1 at t+1; earliest next accept t+3 plus the frame time (10*CLKS_PER_BIT of uart_tx).
- Lock and pointer update, applied at accept:
  - LOCK=1, req_last=0 → locked<=1.
  - req_last=1 or LOCK=0 → locked<=0 and pointer<=(winner+1) mod NUM_REQ.
  - While locked, pointer is unchanged.
- Timeout: in IDLE with locked=1 and req_valid[grant_id]=0, the counter increments. It clears on any accept or when leaving lock.
  - At count == LOCK_TIMEOUT-1: locked<=0, pointer<=grant_id+1 mod NUM_REQ, counter<=0.
  - No accept happens in that same cycle.
- Simultaneous requests: exactly one winner; losers hold valid and data stable until ready; req_data of non-winners is ignored.
- tx_empty=0 while in IDLE (transmitter busy from an external cause or an uart_tx reset mismatch): no req_ready; wait.
- Requester deasserting valid without acceptance is legal; no state change.
- grant_id is meaningful only after the first accept (reads 0 after reset).
- Wrap-around: pointer at NUM_REQ-1 with req_valid[0] set selects 0.

Test Plan:
1. Reset then single requester 2 sends 0x55, req_last=1 → req_ready[2] one cycle; tx_we pulse next cycle with tx_din=0x55; busy until uart_tx empty rises; locked=0, pointer=3.
2. All four valid continuously, LOCK=0, bytes 0xA0+i → uart_tx sees A0,A1,A2,A3,A0… strictly rotating; never two tx_we without an empty 0→1 cycle between.
3. LOCK=1: req1 sends 3 bytes "abc" (last on 'c') while req0 and req3 valid → output a,b,c then 3's byte then 0's; locked=1 during a/b.
4. LOCK=1, LOCK_TIMEOUT=16: req0 sends one non-last byte then drops valid, req2 valid → 16 idle cycles in IDLE, locked falls, req2 byte accepted next cycle; grant_id=2.
5. rst asserted for one cycle while in WAIT_DONE → next cycle state IDLE, tx_we=0, locked=0, pointer=0. With tx_empty=1 and req_valid=0b1000, req_ready=0b1000 the following cycle.
6. Hold tx_empty=0 in IDLE with req_valid=0b0001 for 50 cycles → req_ready stays 0, no tx_we; release → accept within 1 cycle.
